ysyx_24110006_arb: RTL and testbench
====================================

YSYX_24110006_ARB -- requirements
Module: ysyx_24110006_arb

Interface
REQ-001 SHALL have parameter ARB_MODE, default 0, meaning 0 = fixed priority to LSU, 1 = round-robin.
REQ-002 SHALL have i_clock, input, 1, clock; all state changes on its rising edge.
REQ-003 SHALL have i_reset, input, 1, reset, synchronous, active-high.
REQ-004 SHALL have IFU AR inputs i_ifu_araddr, i_ifu_arvalid, i_ifu_arid, i_ifu_arlen, i_ifu_arsize, i_ifu_arburst, widths 32/1/4/8/3/2, meaning IFU read-address request.
REQ-005 SHALL have o_ifu_arready, output, 1, meaning IFU address accepted.
REQ-006 SHALL have IFU R outputs o_ifu_rdata, o_ifu_rvalid, o_ifu_rresp, o_ifu_rid, o_ifu_rlast, widths 32/1/2/4/1, plus i_ifu_rready, input, 1, meaning IFU read-data channel.
REQ-007 SHALL have LSU AR inputs i_lsu_ar* and output o_lsu_arready, plus LSU R outputs o_lsu_r* and input i_lsu_rready, with the same names, widths and meanings as REQ-004 to REQ-006.
REQ-008 SHALL have downstream AR outputs o_axi_araddr, o_axi_arvalid, o_axi_arid, o_axi_arlen, o_axi_arsize, o_axi_arburst, widths 32/1/4/8/3/2, plus i_axi_arready, input, 1, meaning shared read-address channel.
REQ-009 SHALL have downstream R inputs i_axi_rdata, i_axi_rvalid, i_axi_rresp, i_axi_rid, i_axi_rlast, widths 32/1/2/4/1, plus o_axi_rready, output, 1, meaning shared read-data channel.
REQ-010 SHALL have o_busy, output, 1, meaning arbiter is not in IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, IFU_AR, IFU_R, LSU_AR and LSU_R, with a registered state.
REQ-012 From IDLE, the FSM SHALL go to IFU_AR when only i_ifu_arvalid is high, and to LSU_AR when only i_lsu_arvalid is high.
REQ-013 When both requests are high in IDLE: if ARB_MODE=0, the LSU SHALL win; if ARB_MODE=1, the master not granted last SHALL win (last-grant register resets to IFU, so the LSU wins first).
REQ-014 The grant SHALL be registered, so o_axi_arvalid rises no earlier than 1 cycle after the requester's arvalid.
REQ-015 In state X_AR, the AR fields, o_axi_arvalid and X's arready SHALL be combinationally routed between the granted master and the downstream port (o_axi_arvalid = X arvalid; X arready = i_axi_arready).
REQ-016 On an AR handshake (arvalid && arready), the FSM SHALL move from X_AR to X_R.
REQ-017 In state X_R, the R fields SHALL route from downstream to X, X's rvalid SHALL equal i_axi_rvalid, and o_axi_rready SHALL equal X's rready.
REQ-018 In X_R, each beat SHALL pass through unaltered; the FSM SHALL return to IDLE only on the beat where rvalid && rready && rlast.
REQ-019 A burst of any arlen (0..255) SHALL be held by a single grant, with no interleaving.
REQ-020 The non-granted master SHALL see arready=0 and rvalid=0 in every state; its request SHALL be held pending, not dropped.
REQ-021 In IDLE, both arready=0, both rvalid=0, o_axi_arvalid=0 and o_axi_rready=0.
REQ-022 The earliest re-grant is the cycle after the last beat.
REQ-023 In X_AR, deassertion of arvalid by the granted master is an AXI protocol violation; the block SHALL remain in X_AR and forward o_axi_arvalid=0.
REQ-024 If i_axi_rvalid arrives in IDLE or in X_AR, it SHALL not be forwarded, and o_axi_rready SHALL stay 0.
REQ-025 Under round-robin, each master SHALL wait for at most one other transaction while continuously requesting.

Reset
REQ-026 While i_reset is high: state=IDLE, last-grant=IFU, all valid/ready outputs 0 and data outputs 0.
REQ-027 A reset asserted mid-transaction SHALL abort it, with no further beats forwarded; downstream is reset by the same i_reset.

Verification
REQ-028 Single IFU read, araddr=0x8000_0000, arlen=0, slave rdata=0xDEAD_BEEF: o_axi_araddr=0x8000_0000 one cycle after the request; IFU receives 0xDEAD_BEEF with rlast=1; the FSM is back in IDLE the next cycle.
REQ-029 Simultaneous IFU (0x8000_0000) and LSU (0xA000_0000) requests, ARB_MODE=0: LSU is serviced first, IFU starts on the cycle after LSU's rlast beat, and IFU arready stays 0 throughout.
REQ-030 ARB_MODE=1 with both masters requesting continuously for 4 transactions: grants alternate LSU, IFU, LSU, IFU.
REQ-031 LSU burst with arlen=3 and slave rvalid gapped 1 cycle between beats: 4 beats are delivered in order, the grant is held across the gaps, and IFU is blocked until the 4th beat.
REQ-032 i_reset asserted during the 2nd beat of an arlen=3 burst: the next cycle has state IDLE, o_lsu_rvalid=0 and o_axi_rready=0, and a new IFU request is serviced normally.

Source files
------------

// File: rtl/ysyx_24110006_arb.sv
// Two-master AXI read arbiter: IFU and LSU share one downstream read port.
// A grant is held from the address handshake through the last data beat,
// so bursts are never interleaved between masters.
module ysyx_24110006_arb #(
    parameter int ARB_MODE = 0
) (
    input  logic        i_clock,
    input  logic        i_reset,

    input  logic [31:0] i_ifu_araddr,
    input  logic        i_ifu_arvalid,
    input  logic [3:0]  i_ifu_arid,
    input  logic [7:0]  i_ifu_arlen,
    input  logic [2:0]  i_ifu_arsize,
    input  logic [1:0]  i_ifu_arburst,
    output logic        o_ifu_arready,
    output logic [31:0] o_ifu_rdata,
    output logic        o_ifu_rvalid,
    output logic [1:0]  o_ifu_rresp,
    output logic [3:0]  o_ifu_rid,
    output logic        o_ifu_rlast,
    input  logic        i_ifu_rready,

    input  logic [31:0] i_lsu_araddr,
    input  logic        i_lsu_arvalid,
    input  logic [3:0]  i_lsu_arid,
    input  logic [7:0]  i_lsu_arlen,
    input  logic [2:0]  i_lsu_arsize,
    input  logic [1:0]  i_lsu_arburst,
    output logic        o_lsu_arready,
    output logic [31:0] o_lsu_rdata,
    output logic        o_lsu_rvalid,
    output logic [1:0]  o_lsu_rresp,
    output logic [3:0]  o_lsu_rid,
    output logic        o_lsu_rlast,
    input  logic        i_lsu_rready,

    output logic [31:0] o_axi_araddr,
    output logic        o_axi_arvalid,
    output logic [3:0]  o_axi_arid,
    output logic [7:0]  o_axi_arlen,
    output logic [2:0]  o_axi_arsize,
    output logic [1:0]  o_axi_arburst,
    input  logic        i_axi_arready,
    input  logic [31:0] i_axi_rdata,
    input  logic        i_axi_rvalid,
    input  logic [1:0]  i_axi_rresp,
    input  logic [3:0]  i_axi_rid,
    input  logic        i_axi_rlast,
    output logic        o_axi_rready,

    output logic        o_busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IFU_AR = 3'd1,
        IFU_R  = 3'd2,
        LSU_AR = 3'd3,
        LSU_R  = 3'd4
    } state_t;

    state_t state;
    logic   last_lsu;
    logic   lsu_wins;
    logic   ifu_ar;
    logic   ifu_r;
    logic   lsu_ar;
    logic   lsu_r;

    // LSU takes a contested slot in fixed mode, or in round-robin mode when IFU had the last grant
    assign lsu_wins = i_lsu_arvalid &&
                      (!i_ifu_arvalid || (ARB_MODE == 0) || !last_lsu);

    // Routing is suppressed while reset is held so nothing leaks out before the state settles
    assign ifu_ar = (state == IFU_AR) && !i_reset;
    assign ifu_r  = (state == IFU_R)  && !i_reset;
    assign lsu_ar = (state == LSU_AR) && !i_reset;
    assign lsu_r  = (state == LSU_R)  && !i_reset;

    assign o_busy = (state != IDLE);

    // Grant FSM: decide in IDLE, hold through AR handshake and every data beat up to rlast
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state    <= IDLE;
            last_lsu <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (lsu_wins) begin
                        state    <= LSU_AR;
                        last_lsu <= 1'b1;
                    end else if (i_ifu_arvalid) begin
                        state    <= IFU_AR;
                        last_lsu <= 1'b0;
                    end
                end
                IFU_AR: if (i_ifu_arvalid && i_axi_arready) state <= IFU_R;
                IFU_R:  if (i_axi_rvalid && i_ifu_rready && i_axi_rlast) state <= IDLE;
                LSU_AR: if (i_lsu_arvalid && i_axi_arready) state <= LSU_R;
                LSU_R:  if (i_axi_rvalid && i_lsu_rready && i_axi_rlast) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Steer AR and R channels between the granted master and the shared port; everything else reads zero
    always_comb begin
        o_axi_araddr  = 32'd0;
        o_axi_arvalid = 1'b0;
        o_axi_arid    = 4'd0;
        o_axi_arlen   = 8'd0;
        o_axi_arsize  = 3'd0;
        o_axi_arburst = 2'd0;
        o_axi_rready  = 1'b0;
        o_ifu_arready = 1'b0;
        o_ifu_rdata   = 32'd0;
        o_ifu_rvalid  = 1'b0;
        o_ifu_rresp   = 2'd0;
        o_ifu_rid     = 4'd0;
        o_ifu_rlast   = 1'b0;
        o_lsu_arready = 1'b0;
        o_lsu_rdata   = 32'd0;
        o_lsu_rvalid  = 1'b0;
        o_lsu_rresp   = 2'd0;
        o_lsu_rid     = 4'd0;
        o_lsu_rlast   = 1'b0;
        if (ifu_ar) begin
            o_axi_araddr  = i_ifu_araddr;
            o_axi_arvalid = i_ifu_arvalid;
            o_axi_arid    = i_ifu_arid;
            o_axi_arlen   = i_ifu_arlen;
            o_axi_arsize  = i_ifu_arsize;
            o_axi_arburst = i_ifu_arburst;
            o_ifu_arready = i_axi_arready;
        end
        if (lsu_ar) begin
            o_axi_araddr  = i_lsu_araddr;
            o_axi_arvalid = i_lsu_arvalid;
            o_axi_arid    = i_lsu_arid;
            o_axi_arlen   = i_lsu_arlen;
            o_axi_arsize  = i_lsu_arsize;
            o_axi_arburst = i_lsu_arburst;
            o_lsu_arready = i_axi_arready;
        end
        if (ifu_r) begin
            o_ifu_rdata  = i_axi_rdata;
            o_ifu_rvalid = i_axi_rvalid;
            o_ifu_rresp  = i_axi_rresp;
            o_ifu_rid    = i_axi_rid;
            o_ifu_rlast  = i_axi_rlast;
            o_axi_rready = i_ifu_rready;
        end
        if (lsu_r) begin
            o_lsu_rdata  = i_axi_rdata;
            o_lsu_rvalid = i_axi_rvalid;
            o_lsu_rresp  = i_axi_rresp;
            o_lsu_rid    = i_axi_rid;
            o_lsu_rlast  = i_axi_rlast;
            o_axi_rready = i_lsu_rready;
        end
    end

endmodule

// File: tb/tb_ysyx_24110006_arb.sv
// Directed bench for the IFU/LSU read arbiter. Two instances share every input:
// dut_f uses fixed LSU priority, dut_r uses round-robin.
module tb_ysyx_24110006_arb;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b1;
    logic [31:0] ifu_araddr = '0;
    logic        ifu_arvalid = 1'b0;
    logic [3:0]  ifu_arid = 4'd1;
    logic [7:0]  ifu_arlen = '0;
    logic [2:0]  ifu_arsize = 3'd2;
    logic [1:0]  ifu_arburst = 2'd1;
    logic        ifu_rready = 1'b1;
    logic [31:0] lsu_araddr = '0;
    logic        lsu_arvalid = 1'b0;
    logic [3:0]  lsu_arid = 4'd2;
    logic [7:0]  lsu_arlen = '0;
    logic [2:0]  lsu_arsize = 3'd2;
    logic [1:0]  lsu_arburst = 2'd1;
    logic        lsu_rready = 1'b1;
    logic        axi_arready = 1'b1;
    logic [31:0] axi_rdata = '0;
    logic        axi_rvalid = 1'b0;
    logic [1:0]  axi_rresp = '0;
    logic [3:0]  axi_rid = '0;
    logic        axi_rlast = 1'b0;

    logic        f_ifu_arready, f_ifu_rvalid, f_ifu_rlast, f_lsu_arready, f_lsu_rvalid, f_lsu_rlast;
    logic        f_axi_arvalid, f_axi_rready, f_busy;
    logic [31:0] f_ifu_rdata, f_lsu_rdata, f_axi_araddr;
    logic [1:0]  f_ifu_rresp, f_lsu_rresp, f_axi_arburst;
    logic [3:0]  f_ifu_rid, f_lsu_rid, f_axi_arid;
    logic [7:0]  f_axi_arlen;
    logic [2:0]  f_axi_arsize;

    logic        r_ifu_arready, r_ifu_rvalid, r_ifu_rlast, r_lsu_arready, r_lsu_rvalid, r_lsu_rlast;
    logic        r_axi_arvalid, r_axi_rready, r_busy;
    logic [31:0] r_ifu_rdata, r_lsu_rdata, r_axi_araddr;
    logic [1:0]  r_ifu_rresp, r_lsu_rresp, r_axi_arburst;
    logic [3:0]  r_ifu_rid, r_lsu_rid, r_axi_arid;
    logic [7:0]  r_axi_arlen;
    logic [2:0]  r_axi_arsize;

    int checks = 0;
    int errors = 0;

    always #5 i_clock = ~i_clock;

    ysyx_24110006_arb #(.ARB_MODE(0)) dut_f (
        .i_clock(i_clock), .i_reset(i_reset),
        .i_ifu_araddr(ifu_araddr), .i_ifu_arvalid(ifu_arvalid), .i_ifu_arid(ifu_arid),
        .i_ifu_arlen(ifu_arlen), .i_ifu_arsize(ifu_arsize), .i_ifu_arburst(ifu_arburst),
        .o_ifu_arready(f_ifu_arready), .o_ifu_rdata(f_ifu_rdata), .o_ifu_rvalid(f_ifu_rvalid),
        .o_ifu_rresp(f_ifu_rresp), .o_ifu_rid(f_ifu_rid), .o_ifu_rlast(f_ifu_rlast),
        .i_ifu_rready(ifu_rready),
        .i_lsu_araddr(lsu_araddr), .i_lsu_arvalid(lsu_arvalid), .i_lsu_arid(lsu_arid),
        .i_lsu_arlen(lsu_arlen), .i_lsu_arsize(lsu_arsize), .i_lsu_arburst(lsu_arburst),
        .o_lsu_arready(f_lsu_arready), .o_lsu_rdata(f_lsu_rdata), .o_lsu_rvalid(f_lsu_rvalid),
        .o_lsu_rresp(f_lsu_rresp), .o_lsu_rid(f_lsu_rid), .o_lsu_rlast(f_lsu_rlast),
        .i_lsu_rready(lsu_rready),
        .o_axi_araddr(f_axi_araddr), .o_axi_arvalid(f_axi_arvalid), .o_axi_arid(f_axi_arid),
        .o_axi_arlen(f_axi_arlen), .o_axi_arsize(f_axi_arsize), .o_axi_arburst(f_axi_arburst),
        .i_axi_arready(axi_arready), .i_axi_rdata(axi_rdata), .i_axi_rvalid(axi_rvalid),
        .i_axi_rresp(axi_rresp), .i_axi_rid(axi_rid), .i_axi_rlast(axi_rlast),
        .o_axi_rready(f_axi_rready), .o_busy(f_busy)
    );

    ysyx_24110006_arb #(.ARB_MODE(1)) dut_r (
        .i_clock(i_clock), .i_reset(i_reset),
        .i_ifu_araddr(ifu_araddr), .i_ifu_arvalid(ifu_arvalid), .i_ifu_arid(ifu_arid),
        .i_ifu_arlen(ifu_arlen), .i_ifu_arsize(ifu_arsize), .i_ifu_arburst(ifu_arburst),
        .o_ifu_arready(r_ifu_arready), .o_ifu_rdata(r_ifu_rdata), .o_ifu_rvalid(r_ifu_rvalid),
        .o_ifu_rresp(r_ifu_rresp), .o_ifu_rid(r_ifu_rid), .o_ifu_rlast(r_ifu_rlast),
        .i_ifu_rready(ifu_rready),
        .i_lsu_araddr(lsu_araddr), .i_lsu_arvalid(lsu_arvalid), .i_lsu_arid(lsu_arid),
        .i_lsu_arlen(lsu_arlen), .i_lsu_arsize(lsu_arsize), .i_lsu_arburst(lsu_arburst),
        .o_lsu_arready(r_lsu_arready), .o_lsu_rdata(r_lsu_rdata), .o_lsu_rvalid(r_lsu_rvalid),
        .o_lsu_rresp(r_lsu_rresp), .o_lsu_rid(r_lsu_rid), .o_lsu_rlast(r_lsu_rlast),
        .i_lsu_rready(lsu_rready),
        .o_axi_araddr(r_axi_araddr), .o_axi_arvalid(r_axi_arvalid), .o_axi_arid(r_axi_arid),
        .o_axi_arlen(r_axi_arlen), .o_axi_arsize(r_axi_arsize), .o_axi_arburst(r_axi_arburst),
        .i_axi_arready(axi_arready), .i_axi_rdata(axi_rdata), .i_axi_rvalid(axi_rvalid),
        .i_axi_rresp(axi_rresp), .i_axi_rid(axi_rid), .i_axi_rlast(axi_rlast),
        .o_axi_rready(r_axi_rready), .o_busy(r_busy)
    );

    // Advance one clock; inputs change 1 time unit after the rising edge
    task automatic cyc();
        @(posedge i_clock);
        #1;
    endtask

    task automatic beat(input logic [31:0] data, input logic last);
        axi_rvalid = 1'b1;
        axi_rdata  = data;
        axi_rlast  = last;
        #1;
    endtask

    task automatic no_beat();
        axi_rvalid = 1'b0;
        axi_rlast  = 1'b0;
        axi_rdata  = '0;
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        ifu_arvalid = 1'b1;
        axi_rvalid = 1'b1;
        cyc();
        cyc();
        #1;
        checks++; if (f_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, expected 0", f_busy); end
        checks++; if (f_ifu_arready !== 1'b0 || f_axi_arvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_ar: got arready=%b arvalid=%b, expected 0/0", f_ifu_arready, f_axi_arvalid); end
        checks++; if (f_ifu_rvalid !== 1'b0 || f_axi_rready !== 1'b0 || f_axi_araddr !== 32'd0) begin errors++; $display("[TB] FAIL reset_r: got rvalid=%b rready=%b araddr=%h, expected 0/0/0", f_ifu_rvalid, f_axi_rready, f_axi_araddr); end
        ifu_arvalid = 1'b0;
        axi_rvalid = 1'b0;
        i_reset = 1'b0;
        cyc();
    endtask

    task automatic test_single_ifu();
        ifu_araddr = 32'h8000_0000;
        ifu_arlen = 8'd0;
        ifu_arvalid = 1'b1;
        #1;
        checks++; if (f_axi_arvalid !== 1'b0) begin errors++; $display("[TB] FAIL single_unregistered: got arvalid=%b, expected 0", f_axi_arvalid); end
        cyc();
        #1;
        checks++; if (f_axi_araddr !== 32'h8000_0000 || f_axi_arvalid !== 1'b1) begin errors++; $display("[TB] FAIL single_ar: got araddr=%h arvalid=%b, expected 80000000/1", f_axi_araddr, f_axi_arvalid); end
        checks++; if (f_ifu_arready !== 1'b1 || f_lsu_arready !== 1'b0) begin errors++; $display("[TB] FAIL single_arready: got ifu=%b lsu=%b, expected 1/0", f_ifu_arready, f_lsu_arready); end
        cyc();
        ifu_arvalid = 1'b0;
        beat(32'hDEAD_BEEF, 1'b1);
        checks++; if (f_ifu_rdata !== 32'hDEAD_BEEF || f_ifu_rvalid !== 1'b1 || f_ifu_rlast !== 1'b1) begin errors++; $display("[TB] FAIL single_r: got rdata=%h rvalid=%b rlast=%b, expected deadbeef/1/1", f_ifu_rdata, f_ifu_rvalid, f_ifu_rlast); end
        checks++; if (f_axi_rready !== 1'b1 || f_lsu_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL single_rready: got rready=%b lsu_rvalid=%b, expected 1/0", f_axi_rready, f_lsu_rvalid); end
        cyc();
        no_beat();
        checks++; if (f_busy !== 1'b0) begin errors++; $display("[TB] FAIL single_idle: got busy=%b, expected 0", f_busy); end
    endtask

    task automatic test_fixed_priority();
        ifu_araddr = 32'h8000_0000;
        lsu_araddr = 32'hA000_0000;
        ifu_arvalid = 1'b1;
        lsu_arvalid = 1'b1;
        cyc();
        #1;
        checks++; if (f_axi_araddr !== 32'hA000_0000 || f_lsu_arready !== 1'b1 || f_ifu_arready !== 1'b0) begin errors++; $display("[TB] FAIL fixed_lsu_first: got araddr=%h lsu_rdy=%b ifu_rdy=%b, expected a0000000/1/0", f_axi_araddr, f_lsu_arready, f_ifu_arready); end
        cyc();
        lsu_arvalid = 1'b0;
        beat(32'h1111_2222, 1'b1);
        checks++; if (f_lsu_rdata !== 32'h1111_2222 || f_lsu_rvalid !== 1'b1 || f_ifu_rvalid !== 1'b0 || f_ifu_arready !== 1'b0) begin errors++; $display("[TB] FAIL fixed_lsu_r: got rdata=%h lsu_rv=%b ifu_rv=%b ifu_rdy=%b, expected 11112222/1/0/0", f_lsu_rdata, f_lsu_rvalid, f_ifu_rvalid, f_ifu_arready); end
        cyc();
        no_beat();
        checks++; if (f_busy !== 1'b0 || f_ifu_arready !== 1'b0) begin errors++; $display("[TB] FAIL fixed_regrant_idle: got busy=%b ifu_rdy=%b, expected 0/0", f_busy, f_ifu_arready); end
        cyc();
        #1;
        checks++; if (f_axi_araddr !== 32'h8000_0000 || f_ifu_arready !== 1'b1) begin errors++; $display("[TB] FAIL fixed_ifu_second: got araddr=%h ifu_rdy=%b, expected 80000000/1", f_axi_araddr, f_ifu_arready); end
        cyc();
        ifu_arvalid = 1'b0;
        beat(32'h3333_4444, 1'b1);
        checks++; if (f_ifu_rdata !== 32'h3333_4444 || f_ifu_rvalid !== 1'b1) begin errors++; $display("[TB] FAIL fixed_ifu_r: got rdata=%h rvalid=%b, expected 33334444/1", f_ifu_rdata, f_ifu_rvalid); end
        cyc();
        no_beat();
    endtask

    task automatic test_burst_gapped();
        lsu_araddr = 32'hA000_0100;
        lsu_arlen = 8'd3;
        ifu_arvalid = 1'b1;
        lsu_arvalid = 1'b1;
        cyc();
        #1;
        checks++; if (f_axi_arlen !== 8'd3 || f_lsu_arready !== 1'b1) begin errors++; $display("[TB] FAIL burst_ar: got arlen=%0d lsu_rdy=%b, expected 3/1", f_axi_arlen, f_lsu_arready); end
        cyc();
        lsu_arvalid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            beat(32'hC000_0000 + 32'(b), (b == 3));
            checks++; if (f_lsu_rdata !== 32'hC000_0000 + 32'(b) || f_lsu_rvalid !== 1'b1 || f_lsu_rlast !== (b == 3)) begin errors++; $display("[TB] FAIL burst_beat%0d: got rdata=%h rvalid=%b rlast=%b", b, f_lsu_rdata, f_lsu_rvalid, f_lsu_rlast); end
            checks++; if (f_ifu_arready !== 1'b0 || f_ifu_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL burst_ifu_blocked%0d: got arready=%b rvalid=%b, expected 0/0", b, f_ifu_arready, f_ifu_rvalid); end
            cyc();
            if (b < 3) begin
                no_beat();
                checks++; if (f_busy !== 1'b1 || f_lsu_rvalid !== 1'b0 || f_ifu_arready !== 1'b0) begin errors++; $display("[TB] FAIL burst_gap%0d: got busy=%b rvalid=%b ifu_rdy=%b, expected 1/0/0", b, f_busy, f_lsu_rvalid, f_ifu_arready); end
                cyc();
            end
        end
        no_beat();
        checks++; if (f_busy !== 1'b0) begin errors++; $display("[TB] FAIL burst_done: got busy=%b, expected 0", f_busy); end
        cyc();
        #1;
        checks++; if (f_ifu_arready !== 1'b1) begin errors++; $display("[TB] FAIL burst_ifu_next: got ifu_rdy=%b, expected 1", f_ifu_arready); end
        cyc();
        ifu_arvalid = 1'b0;
        beat(32'h5555_6666, 1'b1);
        cyc();
        no_beat();
        lsu_arlen = 8'd0;
    endtask

    task automatic test_protocol_edges();
        beat(32'hBAD0_0000, 1'b1);
        checks++; if (f_ifu_rvalid !== 1'b0 || f_lsu_rvalid !== 1'b0 || f_axi_rready !== 1'b0) begin errors++; $display("[TB] FAIL idle_rvalid: got ifu=%b lsu=%b rready=%b, expected 0/0/0", f_ifu_rvalid, f_lsu_rvalid, f_axi_rready); end
        ifu_araddr = 32'h8000_0040;
        ifu_arvalid = 1'b1;
        cyc();
        #1;
        checks++; if (f_ifu_rvalid !== 1'b0 || f_axi_rready !== 1'b0) begin errors++; $display("[TB] FAIL ar_rvalid: got rvalid=%b rready=%b, expected 0/0", f_ifu_rvalid, f_axi_rready); end
        axi_arready = 1'b0;
        cyc();
        ifu_arvalid = 1'b0;
        #1;
        checks++; if (f_axi_arvalid !== 1'b0 || f_busy !== 1'b1) begin errors++; $display("[TB] FAIL ar_drop: got arvalid=%b busy=%b, expected 0/1", f_axi_arvalid, f_busy); end
        axi_arready = 1'b1;
        cyc();
        #1;
        checks++; if (f_ifu_arready !== 1'b1 || f_ifu_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL ar_hold: got arready=%b rvalid=%b, expected 1/0", f_ifu_arready, f_ifu_rvalid); end
        ifu_arvalid = 1'b1;
        cyc();
        ifu_arvalid = 1'b0;
        #1;
        checks++; if (f_ifu_rvalid !== 1'b1 || f_ifu_rdata !== 32'hBAD0_0000) begin errors++; $display("[TB] FAIL ar_resume: got rvalid=%b rdata=%h, expected 1/bad00000", f_ifu_rvalid, f_ifu_rdata); end
        cyc();
        no_beat();
    endtask

    task automatic test_round_robin();
        logic exp_lsu;
        i_reset = 1'b1;
        cyc();
        i_reset = 1'b0;
        ifu_arvalid = 1'b1;
        lsu_arvalid = 1'b1;
        for (int t = 0; t < 4; t++) begin
            exp_lsu = ((t % 2) == 0);
            cyc();
            #1;
            checks++; if (r_lsu_arready !== exp_lsu || r_ifu_arready !== !exp_lsu) begin errors++; $display("[TB] FAIL rr_grant%0d: got lsu=%b ifu=%b, expected lsu=%b", t, r_lsu_arready, r_ifu_arready, exp_lsu); end
            checks++; if (f_lsu_arready !== 1'b1) begin errors++; $display("[TB] FAIL fixed_grant%0d: got lsu=%b, expected 1", t, f_lsu_arready); end
            cyc();
            beat(32'h7000_0000 + 32'(t), 1'b1);
            checks++; if (r_lsu_rvalid !== exp_lsu || r_ifu_rvalid !== !exp_lsu) begin errors++; $display("[TB] FAIL rr_data%0d: got lsu_rv=%b ifu_rv=%b, expected lsu=%b", t, r_lsu_rvalid, r_ifu_rvalid, exp_lsu); end
            cyc();
            no_beat();
        end
        ifu_arvalid = 1'b0;
        lsu_arvalid = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid_burst();
        lsu_araddr = 32'hA000_0200;
        lsu_arlen = 8'd3;
        lsu_arvalid = 1'b1;
        cyc();
        cyc();
        lsu_arvalid = 1'b0;
        beat(32'hE000_0000, 1'b0);
        cyc();
        beat(32'hE000_0001, 1'b0);
        checks++; if (f_lsu_rvalid !== 1'b1) begin errors++; $display("[TB] FAIL midrst_beat2: got rvalid=%b, expected 1", f_lsu_rvalid); end
        i_reset = 1'b1;
        #1;
        checks++; if (f_lsu_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_during: got rvalid=%b, expected 0", f_lsu_rvalid); end
        cyc();
        i_reset = 1'b0;
        #1;
        checks++; if (f_busy !== 1'b0 || f_lsu_rvalid !== 1'b0 || f_axi_rready !== 1'b0) begin errors++; $display("[TB] FAIL midrst_after: got busy=%b rvalid=%b rready=%b, expected 0/0/0", f_busy, f_lsu_rvalid, f_axi_rready); end
        no_beat();
        lsu_arlen = 8'd0;
        ifu_araddr = 32'h8000_1000;
        ifu_arvalid = 1'b1;
        cyc();
        #1;
        checks++; if (f_axi_araddr !== 32'h8000_1000 || f_ifu_arready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_ifu_ar: got araddr=%h rdy=%b, expected 80001000/1", f_axi_araddr, f_ifu_arready); end
        cyc();
        ifu_arvalid = 1'b0;
        beat(32'h1234_5678, 1'b1);
        checks++; if (f_ifu_rdata !== 32'h1234_5678 || f_ifu_rvalid !== 1'b1) begin errors++; $display("[TB] FAIL midrst_ifu_r: got rdata=%h rvalid=%b, expected 12345678/1", f_ifu_rdata, f_ifu_rvalid); end
        cyc();
        no_beat();
        checks++; if (f_busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_idle: got busy=%b, expected 0", f_busy); end
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_single_ifu();
        test_fixed_priority();
        test_burst_gapped();
        test_protocol_edges();
        test_round_robin();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so a stuck run still terminates
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no completion, expected finish before time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule
